mul_div_unit: RTL

Multi-cycle signed multiply/divide unit for the datapath. Takes operand A from the Y register and operand B from the bus multiplexer output, iterates one bit per clock, and writes a 64-bit result into its own Zhi/Zlo result registers, which return to the bus multiplexer as the Zhi/Zlo sources. Supports MUL (Booth radix-2) and DIV (restoring on magnitudes with sign fix-up), selected per operation by the control unit.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the control unit and the multiply/divide unit.
// The master drives start/op/a/b; the unit (slave) returns the Z registers and status.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  zhi, zlo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output zhi, zlo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth radix-2) / divide (restoring, sign fix-up) unit.
// One bit per clock; a result lands in Zhi/Zlo 33 edges after start is captured.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           clr,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b_mag;
  logic               r_b_neg;
  logic               r_b_zero;
  // MUL: {P_hi (WIDTH+1), P_lo (WIDTH), q-1}; DIV: {R (WIDTH+1), Q (WIDTH), unused}
  logic [2*WIDTH+1:0] r_acc;
  logic [WIDTH-1:0]   r_zhi;
  logic [WIDTH-1:0]   r_zlo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_hi;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH+1:0] w_mul_next;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH+1:0] w_div_next;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_a_mag = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  // Booth step: the extra P_hi bit keeps a = -2^(WIDTH-1) from overflowing.
  assign w_hi    = r_acc[2*WIDTH+1:WIDTH+1];
  assign w_a_ext = {r_a[WIDTH-1], r_a};

  always_comb begin
    w_sum = w_hi;
    case (r_acc[1:0])
      2'b01:   w_sum = w_hi + w_a_ext;
      2'b10:   w_sum = w_hi - w_a_ext;
      default: w_sum = w_hi;
    endcase
  end

  assign w_mul_next = {w_sum[WIDTH], w_sum, r_acc[WIDTH:1]};

  // Restoring step: shift {R,Q} left, keep the trial difference when it is non-negative.
  assign w_rsh      = {r_acc[2*WIDTH:WIDTH+1], r_acc[WIDTH]};
  assign w_diff     = w_rsh - {1'b0, r_b_mag};
  assign w_div_next = w_diff[WIDTH] ? {w_rsh,  r_acc[WIDTH-1:1], 1'b0, 1'b0}
                                    : {w_diff, r_acc[WIDTH-1:1], 1'b1, 1'b0};

  // Both modes leave the 2*WIDTH-bit result in the same slice of the accumulator.
  assign w_r = r_acc[2*WIDTH:WIDTH+1];
  assign w_q = r_acc[WIDTH:1];

  // NOTE: every register here, including the datapath, is reset so zhi/zlo read 0 after clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b_mag  <= '0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_acc    <= '0;
      r_zhi    <= '0;
      r_zlo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_a      <= bus.a;
            r_b_mag  <= w_b_mag;
            r_b_neg  <= bus.b[WIDTH-1];
            r_b_zero <= (bus.b == '0);
            r_acc    <= bus.op ? {{(WIDTH+1){1'b0}}, w_a_mag, 1'b0}
                               : {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= r_op ? w_div_next : w_mul_next;
          if (r_cnt == '0) begin
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FINISH: begin
          if (!r_op) begin
            r_zhi <= w_r;
            r_zlo <= w_q;
          end else if (r_b_zero) begin
            r_zhi <= r_a;
            r_zlo <= '0;
            r_dz  <= 1'b1;
          end else begin
            // Quotient sign from the operand signs; remainder follows the dividend.
            r_zlo <= (r_a[WIDTH-1] ^ r_b_neg) ? (~w_q + 1'b1) : w_q;
            r_zhi <= r_a[WIDTH-1] ? (~w_r + 1'b1) : w_r;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.zhi         = r_zhi;
  assign bus.zlo         = r_zlo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;

endmodule
